rpn_sequencer: RTL
==================

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Infix-to-command sequencer: accepts infix expression tokens and emits the push/operate command stream that drives the stream calculator (op/in/apply interface), using an operator stack (shunting-yard).

Interface
REQ-001 Parameter W, default 8, operand width; SHALL match the calculator data width.
REQ-002 Parameter D, default 8, operator-stack depth (entries).
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tok_valid  input  1  token present.
REQ-006 tok_ready  output  1  token accepted when tok_valid & tok_ready at a rising edge.
REQ-007 tok_kind  input  2  0 number, 1 operator, 2 left paren, 3 right paren.
REQ-008 tok_val  input  W  operand value (kind 0 only).
REQ-009 tok_op  input  3  operator code (kind 1 only): 0 add, 1 sub, 2 mul, 3 div, 4 mod; 5-7 illegal.
REQ-010 tok_last  input  1  token ends the expression.
REQ-011 cmd_apply  output  1  one-cycle command strobe, registered.
REQ-012 cmd_op  output  3  command: 0-4 operate (codes as REQ-009), 7 push.
REQ-013 cmd_in  output  W  push value; 0 for operate commands.
REQ-014 done  output  1  one-cycle pulse, expression fully emitted.
REQ-015 err  output  1  high while in ERR state.

Function
REQ-016 FSM states: ACCEPT, POP_OP, POP_PAREN, FLUSH, ERR; tok_ready SHALL be 1 only in ACCEPT and ERR.
REQ-017 At most one command per cycle; no backpressure on cmd_*; cmd_apply=0 cycles carry cmd_op=0, cmd_in=0.
REQ-018 Precedence: mul/div/mod 2, add/sub 1; all operators left-associative; paren entries on stack have precedence 0.
REQ-019 Syntax flag expect_operand (reset 1): number/left paren legal only when 1; operator/right paren legal only when 0; violation, illegal tok_op, or tok_last while expect_operand=1 after the token -> ERR next cycle.
REQ-020 Number accepted: next cycle cmd_apply=1, cmd_op=7, cmd_in=tok_val; expect_operand<=0.
REQ-021 Operator accepted: if stack top is operator with precedence >= incoming, enter POP_OP holding the incoming op; else push it same edge, no command; expect_operand<=1.
REQ-022 POP_OP: each cycle pop top and emit it (cmd_op=popped code); when stack empty or top precedence < held op, push held op and return to ACCEPT.
REQ-023 Left paren accepted: push, no command.
REQ-024 Right paren accepted: enter POP_PAREN; each cycle pop and emit operators; popping the left paren emits nothing and returns to ACCEPT; stack empty before paren -> ERR.
REQ-025 Any push with D entries already stored -> ERR; no command for that token.
REQ-026 tok_last on a legal token: after that token's pops complete, enter FLUSH; pop and emit one operator per cycle; left paren found -> ERR; stack empty -> done=1 one cycle, expect_operand<=1, ACCEPT.
REQ-027 ERR: err=1, no commands, tokens accepted and dropped; accepting tok_last SHALL clear stack, expect_operand<=1, return to ACCEPT next cycle (err low that cycle).
REQ-028 Latency: first emitted command SHALL appear the cycle after the accepting edge.

Reset
REQ-029 rst SHALL immediately force ACCEPT, empty stack, expect_operand=1, cmd_apply=0, cmd_op=0, cmd_in=0, done=0, err=0, tok_ready=1.
REQ-030 rst asserted mid-POP/FLUSH SHALL abort with no further commands; held operator discarded.

Verification
REQ-031 Tokens 2 + 3 * 4(last) -> push 2, push 3, push 4, op 2, op 0, done pulse one cycle after op 0.
REQ-032 8 - 2 - 1(last) -> push 8, push 2, op 1, push 1, op 1, done; tok_ready low exactly one cycle during the second "-".
REQ-033 ( 1 + 2 ) * 3(last) -> push 1, push 2, op 0, push 3, op 2, done.
REQ-034 ")" as first token -> err=1 next cycle, no cmd_apply; then any token with tok_last -> err=0, ACCEPT.
REQ-035 D=8, nine consecutive "(" -> err=1 after ninth, no commands emitted.
REQ-036 1 + 2 * 3 * 4(last), rst pulsed during FLUSH after first op 2 -> no further cmd_apply, all outputs at REQ-029 values.

Source files
------------

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: shunting-yard converter from infix tokens to push/operate commands
// for the stream calculator, with a bounded operator stack and error recovery.
module rpn_sequencer #(
    parameter int W = 8,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [1:0]   tok_kind,
    input  logic [W-1:0] tok_val,
    input  logic [2:0]   tok_op,
    input  logic         tok_last,
    output logic         cmd_apply,
    output logic [2:0]   cmd_op,
    output logic [W-1:0] cmd_in,
    output logic         done,
    output logic         err
);
    localparam int SPW = $clog2(D + 1);
    localparam int IW = D > 1 ? $clog2(D) : 1;
    localparam logic [2:0] PAREN = 3'd7;
    localparam logic [2:0] PUSH = 3'd7;

    typedef enum logic [2:0] {ACCEPT, POP_OP, POP_PAREN, FLUSH, ERR} state_t;

    state_t         state_q, state_d;
    logic [2:0]     stk_q [D];
    logic [2:0]     stk_d [D];
    logic [SPW-1:0] sp_q, sp_d;
    logic           exp_q, exp_d;
    logic           last_q, last_d;
    logic [2:0]     hold_q, hold_d;
    logic           apply_q, apply_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   in_q, in_d;
    logic           done_q, done_d;
    logic [2:0]     top, nxt;
    logic           empty, full, sp_one, take, bad;

    function automatic logic [1:0] prec(input logic [2:0] e);
        return e == PAREN ? 2'd0 : e >= 3'd2 ? 2'd2 : 2'd1;
    endfunction

    assign top       = stk_q[IW'(sp_q - 1'b1)];
    assign nxt       = stk_q[IW'(sp_q - 2'd2)];
    assign empty     = sp_q == '0;
    assign full      = sp_q == SPW'(D);
    assign sp_one    = sp_q == SPW'(1);
    assign tok_ready = state_q == ACCEPT || state_q == ERR;
    assign take      = tok_valid && tok_ready;
    assign err       = state_q == ERR;
    assign cmd_apply = apply_q;
    assign cmd_op    = op_q;
    assign cmd_in    = in_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        stk_d   = stk_q;
        sp_d    = sp_q;
        exp_d   = exp_q;
        last_d  = last_q;
        hold_d  = hold_q;
        apply_d = 1'b0;
        op_d    = '0;
        in_d    = '0;
        done_d  = 1'b0;
        bad     = (tok_kind[0] == exp_q) || (tok_kind == 2'd1 && tok_op > 3'd4) ||
                  (tok_last && (tok_kind[0] ^ tok_kind[1]));
        case (state_q)
            ACCEPT: if (take) begin
                exp_d  = tok_kind[0] ^ tok_kind[1];
                last_d = tok_last;
                if (bad) state_d = ERR;
                else case (tok_kind)
                    2'd0: begin
                        apply_d = 1'b1;
                        op_d    = PUSH;
                        in_d    = tok_val;
                        state_d = tok_last ? FLUSH : ACCEPT;
                    end
                    2'd1: if (!empty && prec(top) >= prec(tok_op)) begin
                        state_d = POP_OP;
                        hold_d  = tok_op;
                    end else if (full) state_d = ERR;
                    else begin
                        stk_d[IW'(sp_q)] = tok_op;
                        sp_d = sp_q + 1'b1;
                    end
                    2'd2: if (full) state_d = ERR;
                    else begin
                        stk_d[IW'(sp_q)] = PAREN;
                        sp_d = sp_q + 1'b1;
                    end
                    default: state_d = POP_PAREN;
                endcase
            end
            // The held operator takes the popped slot in the same cycle it stops.
            POP_OP: begin
                apply_d = 1'b1;
                op_d    = top;
                if (sp_one || prec(nxt) < prec(hold_q)) begin
                    stk_d[IW'(sp_q - 1'b1)] = hold_q;
                    state_d = ACCEPT;
                end else sp_d = sp_q - 1'b1;
            end
            POP_PAREN: if (empty) state_d = ERR;
            else begin
                sp_d = sp_q - 1'b1;
                if (top == PAREN) state_d = last_q ? FLUSH : ACCEPT;
                else begin
                    apply_d = 1'b1;
                    op_d    = top;
                end
            end
            FLUSH: if (empty) begin
                done_d  = 1'b1;
                exp_d   = 1'b1;
                state_d = ACCEPT;
            end else if (top == PAREN) state_d = ERR;
            else begin
                apply_d = 1'b1;
                op_d    = top;
                sp_d    = sp_q - 1'b1;
            end
            ERR: if (take && tok_last) begin
                sp_d    = '0;
                exp_d   = 1'b1;
                state_d = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ACCEPT;
            sp_q    <= '0;
            exp_q   <= 1'b1;
            last_q  <= 1'b0;
            hold_q  <= '0;
            apply_q <= 1'b0;
            op_q    <= '0;
            in_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            exp_q   <= exp_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            apply_q <= apply_d;
            op_q    <= op_d;
            in_q    <= in_d;
            done_q  <= done_d;
        end

    always_ff @(posedge clk) stk_q <= stk_d;
endmodule
